// File: rtl/knn_stream_feeder_if.sv
// knn_stream_feeder_if
//   Upstream word channel between the host FIFO and the feeder.
//   A word moves on a cycle where valid and ready are both high.
// Signals
//   valid  upstream -> feeder  data holds a word
//   data   upstream -> feeder  word: reference dimensions, then per sample D values and a name
//   ready  feeder -> upstream  feeder takes data this cycle
// Modports
//   master  upstream source (drives valid/data)
//   slave   feeder (drives ready)
interface knn_stream_feeder_if #(
  parameter int dataWidth = 32
);
  logic                 valid;
  logic [dataWidth-1:0] data;
  logic                 ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/knn_stream_feeder.sv
// knn_stream_feeder
//   Transmit side of the knn_top input protocol. Pulls words from the upstream
//   channel, buffers one complete vector, then replays it to knn_top as a
//   gap-free burst: first the reference vector (loadRef), then each sample
//   (D values followed by a name cycle), and finally done.
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle job start, ignored while busy
//   k_in         neighbour count, captured on an accepted start
//   num_samples  sample count N, captured on an accepted start
//   src          upstream word channel (slave side)
//   k            captured neighbour count
//   loadRef      high during the reference burst
//   refDataIn    reference dimension word (0 outside the burst)
//   dataValueIn  sample dimension word (holds outside bursts)
//   dataNameIn   sample name (holds outside bursts)
//   data_valid   high on every sample burst cycle
//   done         end of stream, held until the next accepted start
//   busy         job in progress
module knn_stream_feeder #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [dataWidth-1:0] k_in,
  input  logic [31:0]          num_samples,
  knn_stream_feeder_if.slave   src,
  output logic [dataWidth-1:0] k,
  output logic                 loadRef,
  output logic [dataWidth-1:0] refDataIn,
  output logic [dataWidth-1:0] dataValueIn,
  output logic [dataWidth-1:0] dataNameIn,
  output logic                 data_valid,
  output logic                 done,
  output logic                 busy
);

  localparam int IDX_W = $clog2(numberOfDimensions + 1);
  localparam logic [IDX_W-1:0] IDX_LAST_VAL = IDX_W'(numberOfDimensions - 1);
  localparam logic [IDX_W-1:0] IDX_NAME     = IDX_W'(numberOfDimensions);

  typedef enum logic [2:0] {
    IDLE, REF_FILL, REF_BURST, REF_GAP, FILL, BURST, FINISH
  } state_t;

  state_t state, state_d;

  logic [IDX_W-1:0]     idx, idx_d, idx_inc;
  logic [31:0]          cnt, cnt_d;
  logic                 src_ready, src_ready_d;
  logic [dataWidth-1:0] k_d, refDataIn_d, dataValueIn_d, dataNameIn_d;
  logic                 loadRef_d, data_valid_d, done_d, busy_d;
  logic                 xfer;

  // One full vector: D dimension words plus the sample name in the last slot.
  logic [dataWidth-1:0] vec   [0:numberOfDimensions];
  logic [dataWidth-1:0] vec_d [0:numberOfDimensions];

  assign src.ready = src_ready;
  assign xfer      = src.valid & src_ready;
  assign idx_inc   = idx + 1'b1;

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here are what knn_top sees one clock later. During a
  // burst idx names the word currently on the outputs; during a fill it
  // names the slot the next accepted word goes into. vec_d already carries
  // this cycle's write so a burst can start with a word accepted on the
  // same edge.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    cnt_d         = cnt;
    src_ready_d   = src_ready;
    k_d           = k;
    loadRef_d     = loadRef;
    refDataIn_d   = refDataIn;
    dataValueIn_d = dataValueIn;
    dataNameIn_d  = dataNameIn;
    data_valid_d  = data_valid;
    done_d        = done;
    busy_d        = busy;
    vec_d         = vec;

    case (state)
      IDLE, FINISH: begin
        if (start) begin
          k_d         = k_in;
          cnt_d       = num_samples;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          idx_d       = '0;
          src_ready_d = 1'b1;
          state_d     = REF_FILL;
        end else if (state == FINISH) begin
          state_d = IDLE;
        end
      end

      REF_FILL: begin
        if (xfer) begin
          vec_d[idx] = src.data;
          if (idx == IDX_LAST_VAL) begin
            src_ready_d = 1'b0;
            loadRef_d   = 1'b1;
            refDataIn_d = vec_d[0];
            idx_d       = '0;
            state_d     = REF_BURST;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      REF_BURST: begin
        if (idx == IDX_LAST_VAL) begin
          loadRef_d   = 1'b0;
          refDataIn_d = '0;
          idx_d       = '0;
          state_d     = REF_GAP;
        end else begin
          refDataIn_d = vec[idx_inc];
          idx_d       = idx_inc;
        end
      end

      // A zero-sample job skips straight to done after the reference.
      REF_GAP: begin
        if (cnt == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else begin
          src_ready_d = 1'b1;
          idx_d       = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        if (xfer) begin
          vec_d[idx] = src.data;
          if (idx == IDX_NAME) begin
            src_ready_d   = 1'b0;
            data_valid_d  = 1'b1;
            dataValueIn_d = vec_d[0];
            idx_d         = '0;
            state_d       = BURST;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      // The name cycle leaves dataValueIn on the last dimension word.
      BURST: begin
        if (idx == IDX_NAME) begin
          data_valid_d = 1'b0;
          cnt_d        = cnt - 32'd1;
          if (cnt == 32'd1) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end else begin
            src_ready_d = 1'b1;
            idx_d       = '0;
            state_d     = FILL;
          end
        end else if (idx == IDX_LAST_VAL) begin
          dataNameIn_d = vec[IDX_NAME];
          idx_d        = IDX_NAME;
        end else begin
          dataValueIn_d = vec[idx_inc];
          idx_d         = idx_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops every output to 0 at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      src_ready   <= 1'b0;
      k           <= '0;
      loadRef     <= 1'b0;
      refDataIn   <= '0;
      dataValueIn <= '0;
      dataNameIn  <= '0;
      data_valid  <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      src_ready   <= src_ready_d;
      k           <= k_d;
      loadRef     <= loadRef_d;
      refDataIn   <= refDataIn_d;
      dataValueIn <= dataValueIn_d;
      dataNameIn  <= dataNameIn_d;
      data_valid  <= data_valid_d;
      done        <= done_d;
      busy        <= busy_d;
    end
  end

  // Vector buffer has no reset: its contents are only read after a fill.
  always_ff @(posedge clk) begin
    vec <= vec_d;
  end

endmodule

// File: tb/tb_knn_stream_feeder.sv
// tb_knn_stream_feeder
//   Self-checking bench for knn_stream_feeder. A source process feeds words
//   from a queue with a random stall rate, a monitor records what knn_top
//   would see, and each test compares that against the burst stream expected
//   from the reference vector and sample list.
module tb_knn_stream_feeder;
  localparam int DW = 32;
  localparam int D  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] k_in;
  logic [31:0]   num_samples;
  logic [DW-1:0] k, refDataIn, dataValueIn, dataNameIn;
  logic          loadRef, data_valid, done, busy;

  knn_stream_feeder_if #(.dataWidth(DW)) src_if ();

  knn_stream_feeder #(.dataWidth(DW), .numberOfDimensions(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_in        (k_in),
    .num_samples (num_samples),
    .src         (src_if),
    .k           (k),
    .loadRef     (loadRef),
    .refDataIn   (refDataIn),
    .dataValueIn (dataValueIn),
    .dataNameIn  (dataNameIn),
    .data_valid  (data_valid),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Source side
  logic [DW-1:0] src_q[$];
  int            stall_pct = 0;
  bit            xfer_seen = 1'b0;

  // Job description and expected stream
  logic [DW-1:0] ref_vec[$];
  logic [DW-1:0] samp_words[$];
  logic [DW-1:0] exp_ref[$], exp_val[$], exp_name[$];
  logic [DW-1:0] exp_k = '0;

  // Observed stream
  logic [DW-1:0] obs_ref[$], obs_val[$], obs_name[$];
  int            run_len_q[$], dv_start_q[$], ref_start_q[$], xfer_cyc_q[$];
  int            cyc = 0, done_cyc = -1, last_dv_cyc = -1, run_len = 0, k_bad = 0;
  logic [DW-1:0] last_name = '0;
  bit            prev_load = 1'b0, prev_dv = 1'b0, prev_done = 1'b0;

  // Upstream source: offers the head of src_q, dropping valid at random.
  initial begin
    src_if.valid = 1'b0;
    src_if.data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (xfer_seen && src_q.size() > 0) void'(src_q.pop_front());
      src_if.valid = (src_q.size() > 0) && ($urandom_range(99) >= stall_pct);
      src_if.data  = (src_q.size() > 0) ? src_q[0] : $urandom;
    end
  end

  // Monitor sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    cyc++;
    xfer_seen = src_if.valid && src_if.ready;
    if (xfer_seen) xfer_cyc_q.push_back(cyc);
    if (loadRef) begin
      obs_ref.push_back(refDataIn);
      if (!prev_load) ref_start_q.push_back(cyc);
    end
    if (data_valid) begin
      if (!prev_dv) begin
        dv_start_q.push_back(cyc);
        run_len = 0;
      end
      obs_val.push_back(dataValueIn);
      run_len++;
      last_name = dataNameIn;
    end else if (prev_dv) begin
      run_len_q.push_back(run_len);
      obs_name.push_back(last_name);
      last_dv_cyc = cyc - 1;
    end
    if (done && !prev_done) done_cyc = cyc;
    if (busy && k !== exp_k) k_bad++;
    prev_load = loadRef;
    prev_dv   = data_valid;
    prev_done = done;
  end

  task automatic clear_obs();
    obs_ref.delete(); obs_val.delete(); obs_name.delete();
    run_len_q.delete(); dv_start_q.delete(); ref_start_q.delete(); xfer_cyc_q.delete();
    done_cyc = -1; last_dv_cyc = -1; k_bad = 0;
  endtask

  // Expected knn_top stream: the reference once, then per sample its D values,
  // the last value repeated on the name cycle, and the name.
  task automatic build_model();
    exp_ref.delete(); exp_val.delete(); exp_name.delete();
    foreach (ref_vec[i]) exp_ref.push_back(ref_vec[i]);
    for (int s = 0; s < samp_words.size() / (D + 1); s++) begin
      for (int j = 0; j < D; j++) exp_val.push_back(samp_words[s*(D+1) + j]);
      exp_val.push_back(samp_words[s*(D+1) + D - 1]);
      exp_name.push_back(samp_words[s*(D+1) + D]);
    end
  endtask

  task automatic load_source();
    src_q.delete();
    foreach (ref_vec[i]) src_q.push_back(ref_vec[i]);
    foreach (samp_words[i]) src_q.push_back(samp_words[i]);
  endtask

  task automatic pulse_start(input logic [DW-1:0] kv, input int n);
    @(posedge clk); #1;
    k_in = kv; num_samples = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k_in = $urandom;
  endtask

  task automatic run_job(input logic [DW-1:0] kv, input int n, input bit mid_start, output bit ok);
    clear_obs();
    build_model();
    load_source();
    exp_k = kv;
    pulse_start(kv, n);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (mid_start && c == 20) begin
        start = 1'b1; k_in = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; k_in = '0; num_samples = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({loadRef, data_valid, done, busy, src_if.ready} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b want 00000", {loadRef, data_valid, done, busy, src_if.ready});
    end
    compared++;
    if (k !== '0 || refDataIn !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_k_ref: got k=%0h ref=%0h want 0", k, refDataIn);
    end
    compared++;
    if (dataValueIn !== '0 || dataNameIn !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got val=%0h name=%0h want 0", dataValueIn, dataNameIn);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, src_if.ready, loadRef, data_valid} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_after_reset: got %b want 0000", {busy, src_if.ready, loadRef, data_valid});
    end
  endtask

  task automatic test_stream(input string name, input bit use_spec, input int stall, input bit mid_start);
    int            spec_ref[5]   = '{1, 2, 2, 2, 3};
    int            spec_samp[24] = '{5, 10, 7, 9, 6, 0,  1, 1, 1, 1, 1, 1,
                                     2, 2, 2, 2, 2, 2,   5, 5, 5, 5, 5, 3};
    int            n;
    logic [DW-1:0] kv;
    bit            ok;
    ref_vec.delete(); samp_words.delete();
    if (use_spec) begin
      n = 4; kv = 32'd3;
      foreach (spec_ref[i]) ref_vec.push_back(spec_ref[i]);
      foreach (spec_samp[i]) samp_words.push_back(spec_samp[i]);
    end else begin
      n = $urandom_range(1, 4); kv = $urandom;
      for (int i = 0; i < D; i++) ref_vec.push_back($urandom);
      for (int i = 0; i < n * (D + 1); i++) samp_words.push_back($urandom);
    end
    stall_pct = stall;
    run_job(kv, n, mid_start, ok);

    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s done_timeout: got done=%b want 1 within budget", name, done);
    end
    compared++;
    if (ref_start_q.size() != 1 || obs_ref.size() != D) begin
      mismatched++;
      $display("[TB] FAIL %s ref_burst_shape: got %0d bursts/%0d words want 1/%0d", name, ref_start_q.size(), obs_ref.size(), D);
    end
    for (int i = 0; i < D && i < obs_ref.size(); i++) begin
      compared++;
      if (obs_ref[i] !== exp_ref[i]) begin
        mismatched++;
        $display("[TB] FAIL %s ref_word[%0d]: got %0h want %0h", name, i, obs_ref[i], exp_ref[i]);
      end
    end
    compared++;
    if (run_len_q.size() != n) begin
      mismatched++;
      $display("[TB] FAIL %s burst_count: got %0d want %0d", name, run_len_q.size(), n);
    end
    foreach (run_len_q[s]) begin
      compared++;
      if (run_len_q[s] != D + 1) begin
        mismatched++;
        $display("[TB] FAIL %s burst_len[%0d]: got %0d want %0d", name, s, run_len_q[s], D + 1);
      end
    end
    compared++;
    if (obs_val.size() != exp_val.size()) begin
      mismatched++;
      $display("[TB] FAIL %s value_count: got %0d want %0d", name, obs_val.size(), exp_val.size());
    end
    for (int i = 0; i < obs_val.size() && i < exp_val.size(); i++) begin
      compared++;
      if (obs_val[i] !== exp_val[i]) begin
        mismatched++;
        $display("[TB] FAIL %s value[%0d]: got %0h want %0h", name, i, obs_val[i], exp_val[i]);
      end
    end
    for (int s = 0; s < obs_name.size() && s < exp_name.size(); s++) begin
      compared++;
      if (obs_name[s] !== exp_name[s]) begin
        mismatched++;
        $display("[TB] FAIL %s name[%0d]: got %0h want %0h", name, s, obs_name[s], exp_name[s]);
      end
    end
    compared++;
    if (xfer_cyc_q.size() != D + n * (D + 1)) begin
      mismatched++;
      $display("[TB] FAIL %s words_taken: got %0d want %0d", name, xfer_cyc_q.size(), D + n * (D + 1));
    end else begin
      compared++;
      if (ref_start_q.size() < 1 || ref_start_q[0] != xfer_cyc_q[D-1] + 1) begin
        mismatched++;
        $display("[TB] FAIL %s ref_latency: got start=%0d want %0d", name,
                 (ref_start_q.size() > 0) ? ref_start_q[0] : -1, xfer_cyc_q[D-1] + 1);
      end
      for (int s = 0; s < n && s < dv_start_q.size(); s++) begin
        compared++;
        if (dv_start_q[s] != xfer_cyc_q[D + (s+1)*(D+1) - 1] + 1) begin
          mismatched++;
          $display("[TB] FAIL %s burst_latency[%0d]: got %0d want %0d", name, s, dv_start_q[s],
                   xfer_cyc_q[D + (s+1)*(D+1) - 1] + 1);
        end
      end
    end
    compared++;
    if (done_cyc != last_dv_cyc + 1) begin
      mismatched++;
      $display("[TB] FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_dv_cyc + 1);
    end
    compared++;
    if (k_bad != 0 || k !== kv) begin
      mismatched++;
      $display("[TB] FAIL %s k_hold: got k=%0h bad_cycles=%0d want k=%0h bad_cycles=0", name, k, k_bad, kv);
    end
    compared++;
    if ({done, busy} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL %s end_flags: got done,busy=%b want 10", name, {done, busy});
    end
  endtask

  task automatic test_zero_samples();
    bit ok;
    ref_vec.delete(); samp_words.delete();
    for (int i = 0; i < D; i++) ref_vec.push_back($urandom);
    stall_pct = 30;
    run_job(32'd9, 0, 1'b0, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL zero_done_timeout: got done=%b want 1", done);
    end
    for (int i = 0; i < D && i < obs_ref.size(); i++) begin
      compared++;
      if (obs_ref[i] !== exp_ref[i]) begin
        mismatched++;
        $display("[TB] FAIL zero_ref_word[%0d]: got %0h want %0h", i, obs_ref[i], exp_ref[i]);
      end
    end
    compared++;
    if (obs_ref.size() != D || obs_val.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL zero_stream_shape: got ref=%0d dv_cycles=%0d want %0d/0", obs_ref.size(), obs_val.size(), D);
    end
    compared++;
    if (ref_start_q.size() != 1 || done_cyc != ref_start_q[0] + D + 1) begin
      mismatched++;
      $display("[TB] FAIL zero_done_timing: got cycle %0d want ref_start+%0d", done_cyc, D + 1);
    end
    compared++;
    if (xfer_cyc_q.size() != D || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_words_taken: got %0d busy=%b want %0d busy=0", xfer_cyc_q.size(), busy, D);
    end
  endtask

  task automatic test_reset_mid_job();
    bit hit = 1'b0;
    ref_vec.delete(); samp_words.delete();
    for (int i = 0; i < D; i++) ref_vec.push_back($urandom);
    for (int i = 0; i < 4 * (D + 1); i++) samp_words.push_back($urandom);
    stall_pct = 0;
    clear_obs();
    build_model();
    load_source();
    exp_k = 32'd3;
    pulse_start(32'd3, 4);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (dv_start_q.size() == 3 && data_valid) begin
        hit = 1'b1;
        break;
      end
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("[TB] FAIL midreset_third_burst: got %0d bursts want 3 within budget", dv_start_q.size());
    end
    reset = 1'b0;
    src_q.delete();
    #1;
    compared++;
    if ({loadRef, data_valid, done, busy, src_if.ready} !== 5'b0 || k !== '0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got flags=%b k=%0h want 00000 k=0",
               {loadRef, data_valid, done, busy, src_if.ready}, k);
    end
    compared++;
    if (dataValueIn !== '0 || dataNameIn !== '0 || refDataIn !== '0) begin
      mismatched++;
      $display("[TB] FAIL midreset_data: got val=%0h name=%0h ref=%0h want 0", dataValueIn, dataNameIn, refDataIn);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, src_if.ready, data_valid} !== 3'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_idle: got %b want 000", {busy, src_if.ready, data_valid});
    end
  endtask

  initial begin
    test_reset();
    test_stream("spec_stream", 1'b1, 0, 1'b0);
    test_stream("spec_stalled", 1'b1, 50, 1'b0);
    test_zero_samples();
    test_stream("start_ignored", 1'b1, 0, 1'b1);
    test_reset_mid_job();
    test_stream("after_reset", 1'b0, 0, 1'b0);
    for (int r = 0; r < 3; r++) test_stream("random_job", 1'b0, $urandom_range(0, 70), 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
